debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  N-channel debouncer for board buttons/switches, the parametrised successor of the single-input debouncer.
//  - One shared sample-tick prescaler; per-channel 2-FF synchroniser, polarity select and stability counter.
//  - Outputs per channel: debounced level, 1-cycle rise/fall pulses, optional long-press pulse.
//  - Feeds mode/lock-on control logic in the clk (100 MHz) domain.
// PARAMETERS
//  N_CH          5        number of independent channels (>=1)
//  TICK_DIV      100000   clk cycles per sample tick (>=2); 1 ms at 100 MHz
//  STABLE_TICKS  4        consecutive mismatching samples required to accept a new level (>=1)
//  LONG_TICKS    1000     ticks of continuous level==1 before btn_long fires (>=1; macro only)
//  INVERT_MASK   '0       N_CH bits; bit i=1 means channel i is active-low at btn_in
// PORTS
//  clk        in   1     system clock
//  reset      in   1     asynchronous, active-high reset
//  btn_in     in   N_CH  raw asynchronous inputs
//  btn_level  out  N_CH  debounced, polarity-corrected level
//  btn_rise   out  N_CH  1-cycle pulse when btn_level goes 0->1
//  btn_fall   out  N_CH  1-cycle pulse when btn_level goes 1->0
//  btn_long   out  N_CH  1-cycle long-press pulse (0 when macro absent)
//  tick       out  1     1-cycle sample strobe (for debug/other blocks)
// BEHAVIOUR
//  Reset values:
//  - All outputs 0; prescaler, stability and hold counters 0.
//  - Synchroniser flops reset to INVERT_MASK, so idle active-low inputs read inactive: no spurious edge after reset.
//  Prescaler:
//  - cnt_t counts 0..TICK_DIV-1, then wraps to 0.
//  - tick=1 (registered) for exactly the cycle after cnt_t==TICK_DIV-1.
//  - First tick is TICK_DIV cycles after reset release; period is exactly TICK_DIV.
//  Input path: s = sync2 ^ INVERT_MASK. Fixed 2-clk synchroniser latency; s is sampled only when tick=1.
//  Stability counter, per channel i (width $clog2(STABLE_TICKS+1)):
//  - tick && s[i]!=level[i] && cnt+1<STABLE_TICKS: cnt++.
//  - tick && s[i]!=level[i] && cnt+1==STABLE_TICKS: level<=s[i], cnt<=0.
//  - tick && s[i]==level[i]: cnt<=0. Any matching sample discards partial progress (glitch rejection).
//  - No tick: cnt and level hold.
//  - STABLE_TICKS=1: level follows s at the first tick showing the change.
//  Edge pulses:
//  - btn_rise/btn_fall are registered with btn_level: high exactly in the first cycle the new level is visible.
//  - Never both set on one channel; never high for two consecutive cycles.
//  - Channels are fully independent; simultaneous changes give same-cycle pulses.
//  Reset mid-operation returns everything to reset values; any partial count is lost.
// CONFIGURATION
//  Macro DEBOUNCE_LONGPRESS_EN.
//  Defined:
//  - Per-channel hold counter ($clog2(LONG_TICKS+1) bits) counts ticks while level==1.
//  - When the counter reaches LONG_TICKS: btn_long pulses 1 cycle, the counter saturates, no repeat.
//  - Counter clears to 0 in the cycle level is 0; the next press re-arms.
//  - Release before LONG_TICKS: no btn_long.
//  Not defined: btn_long tied to 0; no hold counters synthesised; LONG_TICKS ignored.
// TESTING
//  Use TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5, N_CH=3, INVERT_MASK=3'b010 unless stated.
//  1 Reset, btn_in=3'b010 held for 100 clk -> btn_level=0, no rise/fall/long pulses ever.
//  2 ch0 0->1 and held -> btn_rise[0] exactly 1 cycle, coinciding with btn_level[0] rising, on the 3rd tick sampling s[0]=1.
//  3 ch0 toggled every 5 clk for 60 clk, then held 0 -> btn_level[0] stays 0, no pulses. ch0 held 1 for 2 ticks then 0 -> no change.
//  4 ch0 and ch2 driven 0->1 and ch1 driven 1->0 in the same cycle -> rise[0], rise[2], rise[1] in the same cycle; later release gives matching falls.
//  5 Macro on, ch2 held for 12 ticks -> one btn_long[2] pulse 5 ticks after btn_level[2] rises, no repeat; release -> fall, counter clears. Macro off -> btn_long==0 throughout.
//  6 Assert reset with ch0 stability cnt=2, release with input still 1 -> full 3 fresh ticks needed before rise[0].

Source files
------------

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//
// N-channel debouncer for board buttons and switches. One shared prescaler
// produces a sample tick. Each channel has its own 2-FF synchroniser,
// polarity correction and stability counter. A channel takes a new level
// only after STABLE_TICKS consecutive samples that differ from the current
// level. Any sample that matches the current level discards the progress
// made so far, which rejects glitches.
//
// Optional feature: define DEBOUNCE_LONGPRESS_EN to build per-channel hold
// counters. These drive a single btn_long pulse after LONG_TICKS ticks of
// continuous level==1. When the macro is undefined, btn_long is tied to 0
// and no hold counters are built.
//
// Ports:
//   clk        in   1     system clock
//   reset      in   1     asynchronous, active-high reset
//   btn_in     in   N_CH  raw asynchronous inputs
//   btn_level  out  N_CH  debounced, polarity-corrected level
//   btn_rise   out  N_CH  1-cycle pulse when btn_level goes 0->1
//   btn_fall   out  N_CH  1-cycle pulse when btn_level goes 1->0
//   btn_long   out  N_CH  1-cycle long-press pulse (0 without the macro)
//   tick       out  1     1-cycle sample strobe
// -----------------------------------------------------------------------------
module debounce_bank #(
  parameter int              N_CH         = 5,
  parameter int              TICK_DIV     = 100000,
  parameter int              STABLE_TICKS = 4,
  parameter int              LONG_TICKS   = 1000,
  parameter logic [N_CH-1:0] INVERT_MASK  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_long,
  output logic            tick
);

  localparam int              TW          = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST   = TW'(TICK_DIV - 1);
  localparam int              SW          = $clog2(STABLE_TICKS + 1);
  localparam logic [SW-1:0]   STABLE_LAST = SW'(STABLE_TICKS - 1);

  // Out-of-range parameters stop elaboration instead of building wrong hardware.
  if (N_CH < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_params
    $error("debounce_bank: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // Shared prescaler. tick is registered, so it goes high in the cycle after
  // cnt_t reaches TICK_DIV-1. The first tick comes TICK_DIV cycles after reset.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] cnt_t;

  // NOTE: every state register uses non-blocking assignments. All flops then
  // update together at the clock edge, whatever the order of the statements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_t <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (cnt_t == TICK_LAST);
      cnt_t <= (cnt_t == TICK_LAST) ? '0 : cnt_t + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Synchroniser. The flops reset to INVERT_MASK, so an idle active-low input
  // reads as inactive straight after reset and causes no false edge.
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0] sync1, sync2, s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= INVERT_MASK;
      sync2 <= INVERT_MASK;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ INVERT_MASK;

  // ---------------------------------------------------------------------------
  // Stability counters, level and edge pulses. The edge pulses are registered
  // in the same cycle as the level, so each pulse lines up with the first
  // cycle that shows the new level. TICK_DIV >= 2, so the cycle after a tick
  // never holds another tick, and every pulse lasts exactly one cycle.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] stab_cnt [N_CH];

  // NOTE: the counter array is a few flops per channel, not a RAM, so it is
  // reset explicitly. This ensures a reset in the middle of a count loses any
  // partial count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level <= '0;
      btn_rise  <= '0;
      btn_fall  <= '0;
      for (int i = 0; i < N_CH; i++) stab_cnt[i] <= '0;
    end else begin
      btn_rise <= '0;
      btn_fall <= '0;
      if (tick) begin
        for (int i = 0; i < N_CH; i++) begin
          if (s[i] == btn_level[i]) begin
            stab_cnt[i] <= '0;
          end else if (stab_cnt[i] == STABLE_LAST) begin
            stab_cnt[i]  <= '0;
            btn_level[i] <= s[i];
            btn_rise[i]  <= s[i];
            btn_fall[i]  <= ~s[i];
          end else begin
            stab_cnt[i] <= stab_cnt[i] + SW'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Long-press detection (optional).
  // ---------------------------------------------------------------------------
`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int            HW        = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_TICKS);

  logic [HW-1:0] hold_cnt [N_CH];

  // The counter saturates at LONG_TICKS, so a press held for a long time
  // produces one pulse only. A low level clears the counter and re-arms it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_long <= '0;
      for (int i = 0; i < N_CH; i++) hold_cnt[i] <= '0;
    end else begin
      btn_long <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (!btn_level[i]) begin
          hold_cnt[i] <= '0;
        end else if (tick && hold_cnt[i] != LONG_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + HW'(1);
          if (hold_cnt[i] == LONG_LAST) btn_long[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign btn_long = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
`timescale 1ns/1ps
module tb_debounce_bank;

  localparam int         N_CH         = 3;
  localparam int         TICK_DIV     = 4;
  localparam int         STABLE_TICKS = 3;
  localparam int         LONG_TICKS   = 5;
  localparam logic [2:0] INV          = 3'b010;
  localparam logic [2:0] IDLE         = 3'b010;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] btn_in = IDLE;
  logic [2:0] btn_level, btn_rise, btn_fall, btn_long;
  logic       tick;

  debounce_bank #(
    .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS),
    .LONG_TICKS(LONG_TICKS), .INVERT_MASK(INV)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level),
    .btn_rise(btn_rise), .btn_fall(btn_fall), .btn_long(btn_long), .tick(tick)
  );

  always #5 clk = ~clk;

  // A pulse event expected at the negedge that follows sample tick number tag.
  // The tick count restarts from 0 at every reset.
  typedef struct packed {
    int         tag;
    logic [2:0] rise;
    logic [2:0] fall;
    logic [2:0] lng;
  } ev_t;

  ev_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  tick_cnt = 0;

  // Pops the scoreboard whenever the DUT shows a pulse and checks pulse shape.
  task automatic monitor();
    logic [2:0] prev_level = '0, prev_rise = '0, prev_fall = '0, bad;
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        tick_cnt   = 0;
        prev_level = '0;
        prev_rise  = '0;
        prev_fall  = '0;
      end else begin
        if (tick) tick_cnt++;
        if ((btn_rise | btn_fall | btn_long) != 3'b000) begin
          n_assert++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: got tick=%0d rise=%b fall=%b long=%b, expected no pulse",
                     tick_cnt, btn_rise, btn_fall, btn_long);
          end else begin
            e = exp_q.pop_front();
            if (e.tag !== tick_cnt || e.rise !== btn_rise || e.fall !== btn_fall || e.lng !== btn_long) begin
              n_fail++;
              $display("FAIL scoreboard_event: got tick=%0d rise=%b fall=%b long=%b, expected tick=%0d rise=%b fall=%b long=%b",
                       tick_cnt, btn_rise, btn_fall, btn_long, e.tag, e.rise, e.fall, e.lng);
            end
          end
          bad = (btn_rise & btn_fall) | (btn_rise & prev_rise) | (btn_fall & prev_fall)
              | (btn_rise & ~(btn_level & ~prev_level))
              | (btn_fall & ~(~btn_level & prev_level))
              | (btn_long & ~btn_level);
          n_assert++;
          if (bad !== 3'b000) begin
            n_fail++;
            $display("FAIL pulse_shape: got bad=%b (level=%b prev=%b rise=%b fall=%b long=%b), expected 000",
                     bad, btn_level, prev_level, btn_rise, btn_fall, btn_long);
          end
        end
        prev_level = btn_level;
        prev_rise  = btn_rise;
        prev_fall  = btn_fall;
      end
    end
  endtask

  // Returns just after a negedge at which tick is high. An input changed there
  // is first seen by the next sample tick.
  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 4 * TICK_DIV; i++) begin
      @(negedge clk);
      #1;
      if (tick) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_assert++;
      n_fail++;
      $display("FAIL tick_timeout: got no tick in %0d cycles, expected one", 4 * TICK_DIV);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic push(input int tag, input logic [2:0] r, input logic [2:0] f, input logic [2:0] l);
    ev_t e;
    e.tag = tag; e.rise = r; e.fall = f; e.lng = l;
    exp_q.push_back(e);
  endtask

  // 1: reset values, tick timing, idle inputs give no activity.
  task automatic test_reset();
    int first = -1, period = -1;
    #1 reset = 1'b1;
    btn_in = IDLE;
    #1;
    n_assert++;
    if ({btn_level, btn_rise, btn_fall, btn_long, tick} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {btn_level, btn_rise, btn_fall, btn_long, tick});
    end
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 1; i <= 4 * TICK_DIV; i++) begin
      @(negedge clk); #1;
      if (tick) begin first = i; break; end
    end
    n_assert++;
    if (first != TICK_DIV) begin
      n_fail++;
      $display("FAIL first_tick: got cycle %0d, expected %0d", first, TICK_DIV);
    end
    for (int i = 1; i <= 4 * TICK_DIV; i++) begin
      @(negedge clk); #1;
      if (tick) begin period = i; break; end
    end
    n_assert++;
    if (period != TICK_DIV) begin
      n_fail++;
      $display("FAIL tick_period: got %0d, expected %0d", period, TICK_DIV);
    end
    repeat (100 - 2 * TICK_DIV) @(negedge clk);
    #1;
    n_assert++;
    if (btn_level !== 3'b000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle: got level=%b pending=%0d, expected level=000 pending=0",
               btn_level, exp_q.size());
    end
  endtask

  // 2: a single press rises on the 3rd tick that samples it; the release falls.
  task automatic test_single_press();
    int t0;
    wait_tick();
    t0 = tick_cnt;
    btn_in[0] = 1'b1;
    push(t0 + 3, 3'b001, 3'b000, 3'b000);
    wait_ticks(4);
    n_assert++;
    if (btn_level !== 3'b001 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL press_level: got level=%b pending=%0d, expected level=001 pending=0",
               btn_level, exp_q.size());
    end
    btn_in[0] = 1'b0;
    push(t0 + 7, 3'b000, 3'b001, 3'b000);
    wait_ticks(4);
    n_assert++;
    if (btn_level !== 3'b000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL release_level: got level=%b pending=%0d, expected level=000 pending=0",
               btn_level, exp_q.size());
    end
  endtask

  // 3: bounce every 5 clk, then a 2-tick pulse; neither is accepted.
  task automatic test_glitch();
    for (int i = 0; i < 12; i++) begin
      btn_in[0] = ~btn_in[0];
      repeat (5) @(negedge clk);
      #1;
    end
    btn_in[0] = 1'b0;
    wait_ticks(5);
    n_assert++;
    if (btn_level !== 3'b000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bounce_level: got level=%b pending=%0d, expected level=000 pending=0",
               btn_level, exp_q.size());
    end
    wait_tick();
    btn_in[0] = 1'b1;
    wait_ticks(2);
    btn_in[0] = 1'b0;
    wait_ticks(5);
    n_assert++;
    if (btn_level !== 3'b000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL short_press_level: got level=%b pending=%0d, expected level=000 pending=0",
               btn_level, exp_q.size());
    end
  endtask

  // 4: three channels change in the same cycle, including the active-low one.
  task automatic test_simultaneous();
    int t0;
    wait_tick();
    t0 = tick_cnt;
    btn_in = 3'b101;
    push(t0 + 3, 3'b111, 3'b000, 3'b000);
    wait_ticks(4);
    n_assert++;
    if (btn_level !== 3'b111 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL simul_press: got level=%b pending=%0d, expected level=111 pending=0",
               btn_level, exp_q.size());
    end
    btn_in = IDLE;
    push(t0 + 7, 3'b000, 3'b111, 3'b000);
    wait_ticks(4);
    n_assert++;
    if (btn_level !== 3'b000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL simul_release: got level=%b pending=%0d, expected level=000 pending=0",
               btn_level, exp_q.size());
    end
  endtask

  // 5: long hold gives one long pulse, then release and re-arm.
  task automatic test_long_press();
    logic [2:0] lp;
    int t0;
`ifdef DEBOUNCE_LONGPRESS_EN
    lp = 3'b100;
`else
    lp = 3'b000;
`endif
    wait_tick();
    t0 = tick_cnt;
    btn_in[2] = 1'b1;
    push(t0 + 3, 3'b100, 3'b000, 3'b000);
    if (lp != 3'b000) push(t0 + 3 + LONG_TICKS, 3'b000, 3'b000, lp);
    wait_ticks(12);
    btn_in[2] = 1'b0;
    push(t0 + 15, 3'b000, 3'b100, 3'b000);
    wait_ticks(4);
    n_assert++;
    if (btn_level !== 3'b000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL long_hold: got level=%b pending=%0d, expected level=000 pending=0",
               btn_level, exp_q.size());
    end
    wait_tick();
    t0 = tick_cnt;
    btn_in[2] = 1'b1;
    push(t0 + 3, 3'b100, 3'b000, 3'b000);
    if (lp != 3'b000) push(t0 + 3 + LONG_TICKS, 3'b000, 3'b000, lp);
    wait_ticks(9);
    btn_in[2] = 1'b0;
    push(t0 + 12, 3'b000, 3'b100, 3'b000);
    wait_ticks(4);
    n_assert++;
    if (btn_level !== 3'b000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL long_rearm: got level=%b pending=%0d, expected level=000 pending=0",
               btn_level, exp_q.size());
    end
  endtask

  // 6: reset with a partial count of 2; rise needs 3 fresh ticks afterwards.
  task automatic test_reset_mid_count();
    wait_tick();
    btn_in[0] = 1'b1;
    wait_ticks(2);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_assert++;
    if ({btn_level, btn_rise, btn_fall, btn_long, tick} !== 13'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b, expected all zero",
               {btn_level, btn_rise, btn_fall, btn_long, tick});
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    push(3, 3'b001, 3'b000, 3'b000);
    wait_ticks(4);
    n_assert++;
    if (btn_level !== 3'b001 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_rise: got level=%b pending=%0d, expected level=001 pending=0",
               btn_level, exp_q.size());
    end
    btn_in[0] = 1'b0;
    push(7, 3'b000, 3'b001, 3'b000);
    wait_ticks(4);
    n_assert++;
    if (btn_level !== 3'b000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_fall: got level=%b pending=%0d, expected level=000 pending=0",
               btn_level, exp_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_long_press();
    test_reset_mid_count();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
